// File: rtl/branch_sequencer.sv
// Branch resolution sequencer: accepts a decoded branch, waits for its
// operands, resolves the condition and issues a one-cycle redirect/flush.
// Optional delay-slot support is enabled with `define BRANCH_DELAY_SLOT_EN.
module branch_sequencer (
  input  logic        clk,
  input  logic        rst,
  input  logic        br_valid,
  input  logic [2:0]  br_type,
  input  logic [31:0] br_pc,
  input  logic [15:0] br_imm,
  input  logic [31:0] op_a,
  input  logic [31:0] op_b,
  input  logic        op_ready,
  input  logic        slot_done,
  input  logic        cnt_clr,
  output logic        br_ready,
  output logic        stall,
  output logic        redirect,
  output logic [31:0] redirect_pc,
  output logic        flush,
  output logic [15:0] taken_cnt,
  output logic [15:0] ntaken_cnt
);

  localparam int unsigned DataW = 32;
  localparam int unsigned ImmW  = 16;
  localparam int unsigned CntW  = 16;
  localparam int unsigned TypeW = 3;

  // Branch type encoding shared with decode
  localparam logic [TypeW-1:0] BR_NONE = 3'd0;
  localparam logic [TypeW-1:0] BR_BEQ  = 3'd1;
  localparam logic [TypeW-1:0] BR_BNE  = 3'd2;
  localparam logic [TypeW-1:0] BR_BLEZ = 3'd3;
  localparam logic [TypeW-1:0] BR_BGTZ = 3'd4;
  localparam logic [TypeW-1:0] BR_BLTZ = 3'd5;
  localparam logic [TypeW-1:0] BR_BGEZ = 3'd6;

  localparam logic [CntW-1:0] CntMax = '1;

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    WAIT_OPS = 3'd1,
    RESOLVE  = 3'd2,
    REDIRECT = 3'd3
`ifdef BRANCH_DELAY_SLOT_EN
    ,
    SLOT     = 3'd4
`endif
  } state_t;

  state_t            state;
  state_t            nextState;
  logic [TypeW-1:0]  latType;
  logic [DataW-1:0]  latPc;
  logic [ImmW-1:0]   latImm;
  logic [DataW-1:0]  latA;
  logic [DataW-1:0]  latB;
  logic              loadBr;
  logic              loadOps;
  logic              resolveNow;
  logic              taken;
  logic [DataW-1:0]  target;

`ifndef BRANCH_DELAY_SLOT_EN
  // slot_done has no meaning without delay-slot support
  logic unusedSlotDone;
  assign unusedSlotDone = slot_done;
`endif

  // Branch condition on latched operands (signed compares against zero)
  always_comb begin
    taken = 1'b0;
    case (latType)
      BR_BEQ:  taken = (latA == latB);
      BR_BNE:  taken = (latA != latB);
      BR_BLEZ: taken = ($signed(latA) <= 32'sd0);
      BR_BGTZ: taken = ($signed(latA) >  32'sd0);
      BR_BLTZ: taken = ($signed(latA) <  32'sd0);
      BR_BGEZ: taken = ($signed(latA) >= 32'sd0);
      default: taken = 1'b0;
    endcase
  end

  // Target = pc + 4 + sext(imm) * 4, wrapping mod 2^32
  always_comb begin
    target = latPc + DataW'(4) + {{(DataW-ImmW-2){latImm[ImmW-1]}}, latImm, 2'b00};
  end

  // Next-state and datapath load strobes
  always_comb begin
    nextState  = state;
    loadBr     = 1'b0;
    loadOps    = 1'b0;
    resolveNow = 1'b0;
    case (state)
      IDLE: begin
        if (br_valid && (br_type != BR_NONE)) begin
          loadBr = 1'b1;
          if (op_ready) begin
            loadOps   = 1'b1;
            nextState = RESOLVE;
          end else begin
            nextState = WAIT_OPS;
          end
        end
      end
      WAIT_OPS: begin
        if (op_ready) begin
          loadOps   = 1'b1;
          nextState = RESOLVE;
        end
      end
      RESOLVE: begin
        resolveNow = 1'b1;
        if (taken) begin
`ifdef BRANCH_DELAY_SLOT_EN
          nextState = SLOT;
`else
          nextState = REDIRECT;
`endif
        end else begin
          nextState = IDLE;
        end
      end
`ifdef BRANCH_DELAY_SLOT_EN
      SLOT: begin
        if (slot_done) nextState = REDIRECT;
      end
`endif
      REDIRECT: nextState = IDLE;
      default:  nextState = IDLE;
    endcase
  end

  // State register, latched branch fields and registered control outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      latType     <= BR_NONE;
      latPc       <= '0;
      latImm      <= '0;
      latA        <= '0;
      latB        <= '0;
      br_ready    <= 1'b1;
      stall       <= 1'b0;
      redirect    <= 1'b0;
      flush       <= 1'b0;
      redirect_pc <= '0;
    end else begin
      state <= nextState;
      if (loadBr) begin
        latType <= br_type;
        latPc   <= br_pc;
        latImm  <= br_imm;
      end
      if (loadOps) begin
        latA <= op_a;
        latB <= op_b;
      end
      br_ready <= (nextState == IDLE);
      stall    <= (nextState != IDLE);
      redirect <= (nextState == REDIRECT);
      flush    <= (nextState == REDIRECT);
      if (nextState == REDIRECT) redirect_pc <= target;
    end
  end

  // Saturating statistics counters; clear wins over a same-cycle increment
  always_ff @(posedge clk) begin
    if (rst || cnt_clr) begin
      taken_cnt  <= '0;
      ntaken_cnt <= '0;
    end else if (resolveNow) begin
      if (taken && (taken_cnt != CntMax))       taken_cnt  <= taken_cnt + CntW'(1);
      if (!taken && (ntaken_cnt != CntMax))     ntaken_cnt <= ntaken_cnt + CntW'(1);
    end
  end

endmodule

// File: tb/tb_branch_sequencer.sv
// Directed self-checking bench for branch_sequencer.
module tb_branch_sequencer;

  logic        clk = 1'b0;
  logic        rst;
  logic        br_valid;
  logic [2:0]  br_type;
  logic [31:0] br_pc;
  logic [15:0] br_imm;
  logic [31:0] op_a;
  logic [31:0] op_b;
  logic        op_ready;
  logic        slot_done;
  logic        cnt_clr;
  logic        br_ready;
  logic        stall;
  logic        redirect;
  logic [31:0] redirect_pc;
  logic        flush;
  logic [15:0] taken_cnt;
  logic [15:0] ntaken_cnt;

  branch_sequencer dut (
    .clk(clk), .rst(rst), .br_valid(br_valid), .br_type(br_type),
    .br_pc(br_pc), .br_imm(br_imm), .op_a(op_a), .op_b(op_b),
    .op_ready(op_ready), .slot_done(slot_done), .cnt_clr(cnt_clr),
    .br_ready(br_ready), .stall(stall), .redirect(redirect),
    .redirect_pc(redirect_pc), .flush(flush),
    .taken_cnt(taken_cnt), .ntaken_cnt(ntaken_cnt)
  );

  always #5 clk = ~clk;

`ifdef BRANCH_DELAY_SLOT_EN
  localparam int SlotLat = 1;
`else
  localparam int SlotLat = 0;
`endif

  typedef struct {
    logic [2:0]  typ;
    logic [31:0] pc;
    logic [15:0] imm;
    logic [31:0] a;
    logic [31:0] b;
    logic        expTaken;
    logic [31:0] expPc;
  } vec_t;

  vec_t vecs[14];
  int   nCompared = 0;
  int   nFail     = 0;
  int   expTakenCnt = 0;
  int   expNtCnt    = 0;
  logic [31:0] lastPc = 32'h0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    nCompared++;
    if (act !== exp) begin
      nFail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  function automatic int satInc(input int v);
    return (v < 32'hFFFF) ? v + 1 : v;
  endfunction

  // Accept a branch with operands ready, walk it through resolution and check
  task automatic runBranch(input vec_t v, input string tag);
    br_valid = 1'b1; br_type = v.typ; br_pc = v.pc; br_imm = v.imm;
    op_a = v.a; op_b = v.b; op_ready = 1'b1;
    check({tag, " accept br_ready"}, 32'(br_ready), 32'd1);
    step(1);
    br_valid = 1'b0; op_ready = 1'b0; op_a = ~v.a; op_b = v.b + 32'd7;
    check({tag, " resolve stall"}, 32'(stall), 32'd1);
    check({tag, " resolve br_ready"}, 32'(br_ready), 32'd0);
    step(1);
    if (v.expTaken) begin
      expTakenCnt = satInc(expTakenCnt);
      if (SlotLat > 0) step(SlotLat);
      check({tag, " redirect"}, 32'(redirect), 32'd1);
      check({tag, " flush"}, 32'(flush), 32'd1);
      check({tag, " redirect_pc"}, redirect_pc, v.expPc);
      check({tag, " taken_cnt"}, 32'(taken_cnt), 32'(expTakenCnt));
      lastPc = v.expPc;
      step(1);
      check({tag, " post redirect"}, 32'(redirect), 32'd0);
      check({tag, " pc hold"}, redirect_pc, lastPc);
    end else begin
      expNtCnt = satInc(expNtCnt);
      check({tag, " nt redirect"}, 32'(redirect), 32'd0);
      check({tag, " nt pc hold"}, redirect_pc, lastPc);
      check({tag, " ntaken_cnt"}, 32'(ntaken_cnt), 32'(expNtCnt));
    end
    check({tag, " ready again"}, 32'(br_ready), 32'd1);
  endtask

  initial begin
    // type codes: 1 BEQ, 2 BNE, 3 BLEZ, 4 BGTZ, 5 BLTZ, 6 BGEZ, 7 undefined
    vecs[0]  = '{3'd1, 32'h00400000, 16'h0004, 32'd5,        32'd5, 1'b1, 32'h00400014};
    vecs[1]  = '{3'd5, 32'h00400000, 16'h0004, 32'h00000001, 32'd0, 1'b0, 32'h0};
    vecs[2]  = '{3'd5, 32'h00001000, 16'hFFFF, 32'hFFFFFFFF, 32'd0, 1'b1, 32'h00001000};
    vecs[3]  = '{3'd2, 32'h00002000, 16'h0010, 32'd1,        32'd2, 1'b1, 32'h00002044};
    vecs[4]  = '{3'd1, 32'h00002000, 16'h0010, 32'd1,        32'd2, 1'b0, 32'h0};
    vecs[5]  = '{3'd3, 32'h00003000, 16'h0000, 32'd0,        32'd9, 1'b1, 32'h00003004};
    vecs[6]  = '{3'd3, 32'h00003000, 16'h0001, 32'h80000000, 32'd0, 1'b1, 32'h00003008};
    vecs[7]  = '{3'd4, 32'h00004000, 16'h0002, 32'd0,        32'd0, 1'b0, 32'h0};
    vecs[8]  = '{3'd4, 32'h00004000, 16'h0002, 32'h7FFFFFFF, 32'd0, 1'b1, 32'h0000400C};
    vecs[9]  = '{3'd6, 32'h00000000, 16'h8000, 32'd0,        32'd0, 1'b1, 32'hFFFE0004};
    vecs[10] = '{3'd6, 32'h00005000, 16'h0001, 32'hFFFFFFFF, 32'd0, 1'b0, 32'h0};
    vecs[11] = '{3'd7, 32'h00005000, 16'h0001, 32'd0,        32'd0, 1'b0, 32'h0};
    vecs[12] = '{3'd4, 32'h00005000, 16'h0001, 32'h80000000, 32'd0, 1'b0, 32'h0};
    vecs[13] = '{3'd1, 32'hFFFFFFF8, 16'h0001, 32'd3,        32'd3, 1'b1, 32'h00000000};

    rst = 1'b1; br_valid = 1'b0; br_type = 3'd0; br_pc = '0; br_imm = '0;
    op_a = '0; op_b = '0; op_ready = 1'b0; cnt_clr = 1'b0;
    slot_done = (SlotLat > 0);
    step(2);
    check("reset br_ready", 32'(br_ready), 32'd1);
    check("reset stall", 32'(stall), 32'd0);
    check("reset redirect", 32'(redirect), 32'd0);
    check("reset flush", 32'(flush), 32'd0);
    check("reset redirect_pc", redirect_pc, 32'h0);
    check("reset taken_cnt", 32'(taken_cnt), 32'd0);
    check("reset ntaken_cnt", 32'(ntaken_cnt), 32'd0);
    rst = 1'b0;
    step(1);

    for (int i = 0; i < 14; i++) runBranch(vecs[i], $sformatf("vec%0d", i));

    // BR_NONE is consumed with no state change and no count
    br_valid = 1'b1; br_type = 3'd0; op_ready = 1'b1;
    step(1);
    br_valid = 1'b0; op_ready = 1'b0;
    check("none br_ready", 32'(br_ready), 32'd1);
    check("none stall", 32'(stall), 32'd0);
    step(1);
    check("none taken_cnt", 32'(taken_cnt), 32'(expTakenCnt));
    check("none ntaken_cnt", 32'(ntaken_cnt), 32'(expNtCnt));

    // Operand wait: BNE accepted without operands, extra br_valid ignored
    br_valid = 1'b1; br_type = 3'd2; br_pc = 32'h00006000; br_imm = 16'h0003;
    op_a = 32'd4; op_b = 32'd4; op_ready = 1'b0;
    step(1);
    br_type = 3'd1; br_pc = 32'h00009000; br_imm = 16'h0100;
    for (int c = 1; c <= 2; c++) begin
      check($sformatf("wait stall c%0d", c), 32'(stall), 32'd1);
      check($sformatf("wait redirect c%0d", c), 32'(redirect), 32'd0);
      step(1);
    end
    br_valid = 1'b0;
    check("wait stall c3", 32'(stall), 32'd1);
    op_a = 32'd1; op_b = 32'd2; op_ready = 1'b1;
    step(1);
    op_ready = 1'b0; op_a = 32'd0; op_b = 32'd0;
    check("wait resolve stall", 32'(stall), 32'd1);
    check("wait resolve redirect", 32'(redirect), 32'd0);
    step(1);
    if (SlotLat > 0) step(SlotLat);
    expTakenCnt = satInc(expTakenCnt);
    lastPc = 32'h00006010;
    check("wait redirect", 32'(redirect), 32'd1);
    check("wait redirect_pc", redirect_pc, lastPc);
    check("wait taken_cnt", 32'(taken_cnt), 32'(expTakenCnt));
    step(1);
    check("wait ready again", 32'(br_ready), 32'd1);

    // Reset while waiting for operands abandons the branch
    br_valid = 1'b1; br_type = 3'd1; br_pc = 32'h00007000; br_imm = 16'h0001;
    op_a = 32'd8; op_b = 32'd8; op_ready = 1'b0;
    step(1);
    br_valid = 1'b0;
    step(1);
    check("rstmid stall before", 32'(stall), 32'd1);
    rst = 1'b1;
    step(1);
    rst = 1'b0;
    expTakenCnt = 0; expNtCnt = 0; lastPc = 32'h0;
    check("rstmid br_ready", 32'(br_ready), 32'd1);
    check("rstmid stall", 32'(stall), 32'd0);
    check("rstmid redirect_pc", redirect_pc, 32'h0);
    op_ready = 1'b1;
    for (int c = 0; c < 3; c++) begin
      step(1);
      check($sformatf("rstmid no redirect c%0d", c), 32'(redirect), 32'd0);
    end
    op_ready = 1'b0;
    check("rstmid taken_cnt", 32'(taken_cnt), 32'd0);
    check("rstmid ntaken_cnt", 32'(ntaken_cnt), 32'd0);

    // Saturation: preload near the top, then two more taken branches
    force dut.taken_cnt = 16'hFFFE;
    step(1);
    release dut.taken_cnt;
    expTakenCnt = 32'hFFFE;
    runBranch(vecs[0], "sat1");
    runBranch(vecs[0], "sat2");
    runBranch(vecs[1], "sat_nt");

    // Clear in the same cycle as a taken increment
    br_valid = 1'b1; br_type = 3'd1; br_pc = 32'h00008000; br_imm = 16'h0000;
    op_a = 32'd2; op_b = 32'd2; op_ready = 1'b1;
    step(1);
    br_valid = 1'b0; op_ready = 1'b0; cnt_clr = 1'b1;
    step(1);
    cnt_clr = 1'b0;
    if (SlotLat > 0) step(SlotLat);
    check("clr taken_cnt", 32'(taken_cnt), 32'd0);
    check("clr ntaken_cnt", 32'(ntaken_cnt), 32'd0);
    check("clr redirect", 32'(redirect), 32'd1);
    check("clr redirect_pc", redirect_pc, 32'h00008004);
    step(1);

`ifdef BRANCH_DELAY_SLOT_EN
    // Delay slot: slot_done arrives 4 cycles late
    slot_done = 1'b0;
    br_valid = 1'b1; br_type = 3'd1; br_pc = 32'h0000A000; br_imm = 16'h0002;
    op_a = 32'd1; op_b = 32'd1; op_ready = 1'b1;
    step(1);
    br_valid = 1'b0; op_ready = 1'b0;
    step(1);
    for (int c = 0; c < 4; c++) begin
      check($sformatf("slot stall c%0d", c), 32'(stall), 32'd1);
      check($sformatf("slot no redirect c%0d", c), 32'(redirect), 32'd0);
      step(1);
    end
    slot_done = 1'b1;
    step(1);
    check("slot redirect", 32'(redirect), 32'd1);
    check("slot redirect_pc", redirect_pc, 32'h0000A00C);
    step(1);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nFail);
    $finish;
  end

endmodule

// File: doc/branch_sequencer.md
BRANCH_SEQUENCER -- requirements
Module: branch_sequencer

Interface
REQ-001 The block SHALL use one clock; reset is synchronous and active-high, with ports named clk and rst.
REQ-002 The block SHALL have port clk, input, 1 bit: rising-edge clock.
REQ-003 The block SHALL have port rst, input, 1 bit: synchronous active-high reset.
REQ-004 The block SHALL have port br_valid, input, 1 bit: decode presents a branch.
REQ-005 The block SHALL have port br_type, input, 3 bits: BR_* encoding from Control_encode.vh.
REQ-006 The block SHALL have port br_pc, input, 32 bits: PC of the branch.
REQ-007 The block SHALL have port br_imm, input, 16 bits: signed word offset.
REQ-008 The block SHALL have ports op_a and op_b, input, 32 bits each: compare operands.
REQ-009 The block SHALL have port op_ready, input, 1 bit: op_a/op_b are valid (forwarding resolved).
REQ-010 The block SHALL have port slot_done, input, 1 bit: the delay-slot instruction has issued (used only when BRANCH_DELAY_SLOT_EN is defined).
REQ-011 The block SHALL have port cnt_clr, input, 1 bit: clear the statistics counters.
REQ-012 The block SHALL have port br_ready, output, 1 bit: a branch is accepted this cycle.
REQ-013 The block SHALL have port stall, output, 1 bit: hold the front end.
REQ-014 The block SHALL have port redirect, output, 1 bit: one-cycle PC redirect pulse.
REQ-015 The block SHALL have port redirect_pc, output, 32 bits: branch target.
REQ-016 The block SHALL have port flush, output, 1 bit: squash younger wrong-path instructions.
REQ-017 The block SHALL have ports taken_cnt and ntaken_cnt, output, 16 bits each: statistics counters.

Function
REQ-018 The FSM SHALL have the states IDLE, WAIT_OPS, RESOLVE, SLOT and REDIRECT, with SLOT present only when BRANCH_DELAY_SLOT_EN is defined.
REQ-019 IDLE: br_ready=1; when br_valid=1 and br_type!=BR_NONE, the block SHALL latch br_type, br_pc and br_imm.
- If op_ready=1 in the same cycle, it SHALL also latch op_a/op_b and go to RESOLVE.
- Otherwise it SHALL go to WAIT_OPS.
REQ-020 IDLE with br_type==BR_NONE: the branch SHALL be consumed, with no state change and no counter update.
REQ-021 WAIT_OPS: when op_ready=1, the block SHALL latch op_a/op_b and go to RESOLVE; otherwise it SHALL remain in WAIT_OPS indefinitely.
REQ-022 RESOLVE (one cycle): the condition SHALL be evaluated on the latched operands with signed compares.
- BEQ: A==B; BNE: A!=B; BLEZ: A<=0; BGTZ: A>0; BLTZ: A<0; BGEZ: A>=0.
- Undefined encodings SHALL count as not-taken.
REQ-023 The target SHALL be br_pc + 4 + (sign_extend(br_imm) << 2), computed mod 2^32 with wrap-around and no error indication.
REQ-024 RESOLVE transitions SHALL be: taken -> REDIRECT (or SLOT when BRANCH_DELAY_SLOT_EN is defined); not-taken -> IDLE.
REQ-025 REDIRECT: for exactly one cycle the block SHALL drive redirect=1, flush=1 and redirect_pc=target, then go to IDLE.
REQ-026 redirect_pc SHALL hold its last target value at all other times.
REQ-027 stall SHALL be 1 whenever state != IDLE, and br_ready SHALL equal (state==IDLE).
REQ-028 br_valid SHALL be ignored outside IDLE.
REQ-029 Latency with op_ready at acceptance (cycle 0): RESOLVE in cycle 1; redirect in cycle 2 (taken) or br_ready=1 again in cycle 2 (not-taken).
REQ-030 Each resolution SHALL increment taken_cnt or ntaken_cnt by 1 in its RESOLVE cycle, saturating at 0xFFFF.
REQ-031 If cnt_clr is asserted in the same cycle as an increment, the clear SHALL win and the counter SHALL read 0.

Reset
REQ-032 When rst=1 at a clock edge, the block SHALL set state=IDLE, stall=0, redirect=0, flush=0, redirect_pc=0, taken_cnt=0 and ntaken_cnt=0, and discard all latched fields.
REQ-033 A reset asserted mid-operation, in any state, SHALL abandon the branch with no redirect pulse and no count, and br_ready=1 in the first cycle after reset deasserts.

Configuration
REQ-034 With BRANCH_DELAY_SLOT_EN defined: a taken branch SHALL go RESOLVE -> SLOT, wait in SLOT (stall=1) until slot_done=1, and then go to REDIRECT.
REQ-035 If slot_done is already 1 in the RESOLVE cycle, the block SHALL still spend one cycle in SLOT.
REQ-036 Without BRANCH_DELAY_SLOT_EN: there SHALL be no SLOT state, slot_done SHALL be ignored, and taken branches SHALL go directly to REDIRECT.

Verification
REQ-037 BEQ test: br_pc=0x00400000, imm=0x0004, op_a=op_b=5, op_ready=1 -> redirect=1, flush=1 and redirect_pc=0x00400014 in cycle 2; taken_cnt=1.
REQ-038 BLTZ test: op_a=0x00000001 -> no redirect, br_ready=1 in cycle 2, ntaken_cnt=1; repeat with op_a=0xFFFFFFFF -> taken.
REQ-039 Operand wait test: BNE with op_ready=0 for 3 cycles -> stall=1 throughout; the redirect follows 2 cycles after op_ready rises; br_valid pulses during the wait are ignored.
REQ-040 Wrap and reset test:
- imm=0x8000 with br_pc=0x00000000 -> redirect_pc=0xFFFE0004.
- rst asserted while in WAIT_OPS -> no redirect, counters=0.
REQ-041 Saturation and delay-slot test:
- Preload 0xFFFF taken resolutions -> taken_cnt stays at 0xFFFF; cnt_clr together with an increment -> 0.
- With BRANCH_DELAY_SLOT_EN defined, slot_done delayed 4 cycles -> redirect in the cycle after slot_done.
